// File: rtl/maze_map_arbiter.sv
// maze_map_arbiter
// Shares the single-port maze tile RAM among the VGA tile renderer, the
// player move checker and the level loader. In RUN mode the renderer has
// priority, but a move request that has been denied for STARVE_MAX cycles
// takes the port for one cycle. In LOAD mode only the loader may touch the
// RAM; renderer reads are answered with floor tiles so the screen stays sane.
//
//   state | meaning
//   RUN   | normal play: vga > mv > ld, with aging override for mv
//   LOAD  | level load: ld has exclusive write access, vga fed floor tiles
module maze_map_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 2,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_miss,

    input  logic              mv_req,
    input  logic [ADDR_W-1:0] mv_addr,
    output logic              mv_gnt,
    output logic              mv_rvalid,
    output logic [DATA_W-1:0] mv_rdata,

    input  logic              ld_start,
    input  logic              ld_done,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              loading,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_nxt;
    logic        r_vga_rvalid;
    logic        r_vga_floor;
    logic        r_mv_rvalid;
    logic        r_vga_miss;

    logic        w_run;
    logic        w_mv_aged;
    logic        w_vga_gnt;
    logic        w_mv_gnt;
    logic        w_ld_gnt;

    assign w_run     = (r_state == ST_RUN);
    assign w_mv_aged = mv_req && (r_wait_cnt == STARVE_LIM);

    // Mode register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mode transitions; simultaneous start/done is ignored
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (ld_start && !ld_done) w_state_nxt = ST_LOAD;
            ST_LOAD: if (ld_done && !ld_start) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Grant selection: at most one requester owns the port each cycle
    always_comb begin
        w_vga_gnt = 1'b0;
        w_mv_gnt  = 1'b0;
        w_ld_gnt  = 1'b0;
        if (w_run) begin
            if (w_mv_aged) begin
                w_mv_gnt = 1'b1;
            end else if (vga_req) begin
                w_vga_gnt = 1'b1;
            end else if (mv_req) begin
                w_mv_gnt = 1'b1;
            end else if (ld_req) begin
                w_ld_gnt = 1'b1;
            end
        end else begin
            w_ld_gnt = ld_req;
        end
    end

    // RAM port mux driven by whichever requester won
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_vga_gnt) begin
            mem_en   = 1'b1;
            mem_addr = vga_addr;
        end else if (w_mv_gnt) begin
            mem_en   = 1'b1;
            mem_addr = mv_addr;
        end else if (w_ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    // Aging counter next value: frozen at zero during LOAD
    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (!w_run || !mv_req || w_mv_gnt) begin
            w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt < STARVE_LIM) begin
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
    end

    // Aging counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Read-return tracking; the floor flag is captured at request time so a
    // read granted just before a mode switch still returns real RAM data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vga_rvalid <= 1'b0;
            r_vga_floor  <= 1'b0;
            r_mv_rvalid  <= 1'b0;
            r_vga_miss   <= 1'b0;
        end else begin
            r_vga_rvalid <= w_vga_gnt || (!w_run && vga_req);
            r_vga_floor  <= !w_run && vga_req;
            r_mv_rvalid  <= w_mv_gnt;
            r_vga_miss   <= w_run && vga_req && !w_vga_gnt;
        end
    end

    // Output assignment and read-data steering
    assign vga_gnt    = w_vga_gnt;
    assign mv_gnt     = w_mv_gnt;
    assign ld_gnt     = w_ld_gnt;
    assign loading    = (r_state == ST_LOAD);
    assign vga_rvalid = r_vga_rvalid;
    assign vga_miss   = r_vga_miss;
    assign mv_rvalid  = r_mv_rvalid;
    assign vga_rdata  = (r_vga_rvalid && !r_vga_floor) ? mem_rdata : '0;
    assign mv_rdata   = r_mv_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_maze_map_arbiter.sv
// Directed bench for maze_map_arbiter with a small synchronous RAM model.
module tb_maze_map_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       vga_req;
    logic [9:0] vga_addr;
    logic       vga_gnt;
    logic       vga_rvalid;
    logic [1:0] vga_rdata;
    logic       vga_miss;
    logic       mv_req;
    logic [9:0] mv_addr;
    logic       mv_gnt;
    logic       mv_rvalid;
    logic [1:0] mv_rdata;
    logic       ld_start;
    logic       ld_done;
    logic       ld_req;
    logic [9:0] ld_addr;
    logic [1:0] ld_wdata;
    logic       ld_gnt;
    logic       loading;
    logic       mem_en;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata = 2'd0;

    logic [1:0] ram [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    maze_map_arbiter #(.ADDR_W(10), .DATA_W(2), .STARVE_MAX(15)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata), .vga_miss(vga_miss),
        .mv_req(mv_req), .mv_addr(mv_addr), .mv_gnt(mv_gnt),
        .mv_rvalid(mv_rvalid), .mv_rdata(mv_rdata),
        .ld_start(ld_start), .ld_done(ld_done), .ld_req(ld_req),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .loading(loading),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] ld_data [0:3];

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 2'd0;
        ram[5] = 2'd1;
        ram[7] = 2'd2;
        ld_data[0] = 2'd1; ld_data[1] = 2'd2; ld_data[2] = 2'd3; ld_data[3] = 2'd0;

        reset = 1'b1;
        vga_req = 0; vga_addr = 0; mv_req = 0; mv_addr = 0;
        ld_start = 0; ld_done = 0; ld_req = 0; ld_addr = 0; ld_wdata = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_loading", 32'(loading), 0);
        chk("rst_vga_rvalid", 32'(vga_rvalid), 0);
        chk("rst_mv_rvalid", 32'(mv_rvalid), 0);
        chk("rst_vga_miss", 32'(vga_miss), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);

        // vga only, address 5
        tick();
        vga_req = 1; vga_addr = 10'd5;
        #1;
        chk("vga_gnt", 32'(vga_gnt), 1);
        chk("vga_mem_en", 32'(mem_en), 1);
        chk("vga_mem_we", 32'(mem_we), 0);
        chk("vga_mem_addr", 32'(mem_addr), 5);
        chk("vga_mv_gnt", 32'(mv_gnt), 0);
        tick();
        chk("vga_rvalid", 32'(vga_rvalid), 1);
        chk("vga_rdata", 32'(vga_rdata), 1);
        chk("vga_no_miss", 32'(vga_miss), 0);
        chk("vga_mv_rvalid", 32'(mv_rvalid), 0);
        vga_req = 0;

        // reset while a vga read is in flight
        tick();
        vga_req = 1; vga_addr = 10'd5;
        #1;
        chk("rmid_gnt", 32'(vga_gnt), 1);
        reset = 1'b1;
        tick();
        chk("rmid_rvalid", 32'(vga_rvalid), 0);
        chk("rmid_rdata", 32'(vga_rdata), 0);
        chk("rmid_loading", 32'(loading), 0);
        chk("rmid_wait_cnt", 32'(dut.r_wait_cnt), 0);
        reset = 1'b0;
        vga_req = 0;

        // aging: vga and mv stuck high
        tick();
        vga_req = 1; vga_addr = 10'd5;
        mv_req = 1; mv_addr = 10'd7;
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk("age_vga_gnt", 32'(vga_gnt), (k < 16) ? 1 : 0);
            chk("age_mv_gnt", 32'(mv_gnt), (k < 16) ? 0 : 1);
            chk("age_wait_cnt", 32'(dut.r_wait_cnt), 32'(k - 1));
            if (k == 16) chk("age_mem_addr", 32'(mem_addr), 7);
            tick();
        end
        mv_req = 0;
        chk("age_miss", 32'(vga_miss), 1);
        chk("age_mv_rvalid", 32'(mv_rvalid), 1);
        chk("age_mv_rdata", 32'(mv_rdata), 2);
        chk("age_vga_rvalid", 32'(vga_rvalid), 0);
        chk("age_wait_clr", 32'(dut.r_wait_cnt), 0);
        chk("age_vga_regain", 32'(vga_gnt), 1);
        tick();
        chk("age_miss_end", 32'(vga_miss), 0);
        chk("age_vga_rvalid2", 32'(vga_rvalid), 1);
        vga_req = 0;

        // mv beats ld in RUN
        tick();
        mv_req = 1; mv_addr = 10'd5;
        ld_req = 1; ld_addr = 10'd10; ld_wdata = 2'd2;
        #1;
        chk("mvld_mv_gnt", 32'(mv_gnt), 1);
        chk("mvld_ld_gnt", 32'(ld_gnt), 0);
        chk("mvld_we", 32'(mem_we), 0);
        tick();
        mv_req = 0;
        #1;
        chk("mvld_mv_rdata", 32'(mv_rdata), 1);
        chk("mvld_ld_gnt2", 32'(ld_gnt), 1);
        chk("mvld_we2", 32'(mem_we), 1);
        chk("mvld_addr2", 32'(mem_addr), 10);
        chk("mvld_wdata2", 32'(mem_wdata), 2);
        tick();
        ld_req = 0;
        vga_req = 1; vga_addr = 10'd10;
        #1;
        chk("mvld_rb_gnt", 32'(vga_gnt), 1);
        tick();
        vga_req = 0;
        chk("mvld_rb_rdata", 32'(vga_rdata), 2);

        // LOAD mode writes with vga and mv pending
        ld_start = 1;
        tick();
        ld_start = 0;
        chk("load_enter", 32'(loading), 1);
        vga_req = 1; vga_addr = 10'd2;
        mv_req = 1; mv_addr = 10'd5;
        ld_req = 1;
        for (int i = 0; i < 4; i++) begin
            ld_addr = 10'(i); ld_wdata = ld_data[i];
            #1;
            chk("load_ld_gnt", 32'(ld_gnt), 1);
            chk("load_vga_gnt", 32'(vga_gnt), 0);
            chk("load_mv_gnt", 32'(mv_gnt), 0);
            chk("load_we", 32'(mem_we), 1);
            chk("load_addr", 32'(mem_addr), 32'(i));
            chk("load_wdata", 32'(mem_wdata), 32'(ld_data[i]));
            tick();
            chk("load_vga_rvalid", 32'(vga_rvalid), 1);
            chk("load_vga_rdata", 32'(vga_rdata), 0);
            chk("load_vga_miss", 32'(vga_miss), 0);
            chk("load_mv_rvalid", 32'(mv_rvalid), 0);
            chk("load_wait_cnt", 32'(dut.r_wait_cnt), 0);
        end
        ld_req = 0; ld_done = 1;
        #1;
        chk("load_done_mv_gnt", 32'(mv_gnt), 0);
        tick();
        ld_done = 0; mv_req = 0;
        chk("load_exit", 32'(loading), 0);
        chk("load_exit_rvalid", 32'(vga_rvalid), 1);
        chk("load_exit_rdata", 32'(vga_rdata), 0);
        #1;
        chk("run_vga_gnt", 32'(vga_gnt), 1);
        tick();
        chk("run_rd2_rvalid", 32'(vga_rvalid), 1);
        chk("run_rd2_rdata", 32'(vga_rdata), 3);
        vga_req = 0;

        // start and done together in RUN
        ld_start = 1; ld_done = 1;
        tick();
        ld_start = 0; ld_done = 0;
        chk("both_loading", 32'(loading), 0);

        // ld_start while a vga read is granted
        vga_req = 1; vga_addr = 10'd1; ld_start = 1;
        #1;
        chk("mid_gnt", 32'(vga_gnt), 1);
        tick();
        vga_req = 0; ld_start = 0;
        chk("mid_loading", 32'(loading), 1);
        chk("mid_rvalid", 32'(vga_rvalid), 1);
        chk("mid_rdata", 32'(vga_rdata), 2);
        ld_done = 1;
        tick();
        ld_done = 0;
        chk("mid_exit", 32'(loading), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/maze_map_arbiter.md
# maze_map_arbiter

Shares the single-port maze tile RAM (32×24 tiles, 2-bit tile code) among three requesters: the VGA tile renderer, the player move checker and the level loader. Fixed priority with an aging override so player moves are never starved by active video, plus a LOAD mode that gives the loader exclusive write access while the renderer is fed floor tiles. Sits between game logic / vga_controller-driven renderer and the tile RAM in maze_top.

## Interface
- ADDR_W, 10, tile address width (row*32+col, 0..767 used)
- DATA_W, 2, tile code (0 floor, 1 wall, 2 goal, 3 start)
- STARVE_MAX, 15, cycles a pending move request may be denied before it preempts the renderer (1..255)

- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high
- vga_req  in  1  renderer read request
- vga_addr  in  ADDR_W  renderer tile address
- vga_gnt  out  1  renderer granted this cycle
- vga_rvalid  out  1  renderer read data valid
- vga_rdata  out  DATA_W  renderer read data
- vga_miss  out  1  one-cycle pulse: renderer request denied
- mv_req  in  1  move-checker read request
- mv_addr  in  ADDR_W  move-checker tile address
- mv_gnt  out  1  move checker granted this cycle
- mv_rvalid  out  1  move-checker read data valid
- mv_rdata  out  DATA_W  move-checker read data
- ld_start  in  1  pulse: enter LOAD mode
- ld_done  in  1  pulse: leave LOAD mode
- ld_req  in  1  loader write request
- ld_addr  in  ADDR_W  loader write address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader write performed this cycle
- loading  out  1  high while in LOAD mode
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en & !mem_we

## Operation
- Mode FSM, two states: RUN (reset state), LOAD. RUN→LOAD on ld_start; LOAD→RUN on ld_done. Both asserted together: state unchanged. loading = (state==LOAD), registered.
- RUN priority: vga > mv > ld, except aging override. Aging counter wait_cnt (8 bits): cleared when mv_req low or mv_gnt high; else increments, saturating at STARVE_MAX. When mv_req & wait_cnt==STARVE_MAX, mv wins over vga for that cycle.
- LOAD priority: ld only. vga_req and mv_req never granted; each vga_req cycle still yields vga_rvalid next cycle with vga_rdata=0 (floor); vga_miss not asserted in LOAD. Pending mv_req held off; wait_cnt held at 0.
- At most one grant per cycle. Grants, mem_en, mem_we, mem_addr, mem_wdata combinational from current requests and registered state. mem_we=1 only on ld_gnt. mem_wdata=ld_wdata when ld granted, else 0. mem_addr=0 when idle.
- Requester keeps req/addr stable until it sees gnt; next request may start the cycle after gnt.
- vga_miss: registered pulse, high the cycle after vga_req & !vga_gnt in RUN. Renderer reuses its previous tile.
- rdata outputs: mem_rdata routed to the requester whose rvalid is high; 0 otherwise.

## Timing
- Grant: same cycle as request (0-cycle arbitration). Read latency: rvalid/rdata exactly 1 cycle after gnt.
- Write: performed in the gnt cycle; a read of the same address granted next cycle returns new data.
- Worst-case mv wait in RUN with vga_req stuck high: STARVE_MAX+1 cycles from mv_req rise to mv_gnt.
- Reset (any time, async): state=RUN, wait_cnt=0, loading=0, all rvalid=0, vga_miss=0; combinational grants follow from inputs. In-flight read data discarded (no rvalid after reset).
- ld_start mid-read: rvalid for the read granted before the switch still asserts next cycle with real mem_rdata.

## Test plan
- Reset mid-traffic: vga_req=1 granted, assert reset -> next cycle vga_rvalid=0, loading=0, wait_cnt=0.
- vga only, addr 5, RAM holds 1 -> vga_gnt same cycle, vga_rvalid=1, vga_rdata=1 next cycle; mem_we=0.
- vga_req and mv_req held high (STARVE_MAX=15) -> mv_gnt on 16th cycle, vga_gnt=0 that cycle, vga_miss pulse next cycle, wait_cnt back to 0, vga regains grant after.
- vga low, mv_req and ld_req both high in RUN -> mv granted, ld waits; ld_gnt the cycle after mv_req drops.
- ld_start, then writes addr 0..3 with data 1,2,3,0 while vga_req=1 -> ld_gnt each cycle, vga_rvalid with vga_rdata=0, mv never granted; ld_done -> loading=0, vga read addr 2 returns 3.
- ld_start and ld_done same cycle in RUN -> loading stays 0.
